clock_add: RTL and testbench

Count-up stopwatch companion to the countdown `Clock_Sub`: same four-digit MM:SS display format, opposite direction. It divides `CLK` down to a one-second tick and increments a BCD minutes:seconds count from 00:00. It stops and flags completion when the count reaches a captured limit, or runs free and wraps when the limit is 00:00. Its outputs drive the same display digit buses as `Clock_Sub`.

---
 rtl/clock_add.sv | 191 +++++++++++++++++++
 tb/tb_clock_add.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_add.sv
// ---------------------------------------------------------------------------
// clock_add
//   Count-up MM:SS stopwatch. CLK is divided down to a one-second tick that
//   increments a four-digit BCD count starting at 00:00. The count stops and
//   raises done when it reaches the limit captured at start. A limit of 00:00
//   makes it run free, wrapping 99:59 -> 00:00.
//
// Ports
//   CLK                 system clock, rising edge
//   reset               asynchronous reset, active low
//   start               begin from IDLE / resume from PAUSE (level)
//   stop                RUN -> PAUSE (level), beats start
//   clear               synchronous return to IDLE with count 00:00, beats all
//   *_in  [7:0]         limit digits, only bits [3:0] used, clamped at capture
//   seconds_upper/lower, minutes_upper/lower [7:0]
//                       count digits in bits [3:0], bits [7:4] always 0
//   running             high while in RUN
//   done                high while in DONE
//   tick                one-cycle pulse aligned with each new count value
//   dbg_state [1:0]     current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//
// Handshake: there is no valid/ready pair. Control levels are sampled on
//   every rising edge with priority clear > stop > start; all outputs are
//   registered and change only on that edge (or immediately on reset).
// ---------------------------------------------------------------------------
module clock_add #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [7:0] seconds_upper_in,
    input  logic [7:0] seconds_lower_in,
    input  logic [7:0] minutes_upper_in,
    input  logic [7:0] minutes_lower_in,
    output logic [7:0] seconds_upper,
    output logic [7:0] seconds_lower,
    output logic [7:0] minutes_upper,
    output logic [7:0] minutes_lower,
    output logic       running,
    output logic       done,
    output logic       tick,
    output logic [1:0] dbg_state
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_su, r_sl, r_mu, r_ml;
    logic [3:0]      r_lim_su, r_lim_sl, r_lim_mu, r_lim_ml;
    logic            r_running, r_done, r_tick;

    logic [3:0]      w_cap_su, w_cap_sl, w_cap_mu, w_cap_ml;
    logic [3:0]      w_inc_su, w_inc_sl, w_inc_mu, w_inc_ml;
    logic            w_lim_zero, w_hit;
    logic            w_unused_hi;

    // Only the low nibble of each limit byte carries a digit.
    assign w_unused_hi = ^{seconds_upper_in[7:4], seconds_lower_in[7:4],
                           minutes_upper_in[7:4], minutes_lower_in[7:4]};

    // Clamp out-of-range limit digits so the captured limit is always a
    // reachable BCD value.
    assign w_cap_su = (seconds_upper_in[3:0] > 4'd5) ? 4'd5 : seconds_upper_in[3:0];
    assign w_cap_sl = (seconds_lower_in[3:0] > 4'd9) ? 4'd9 : seconds_lower_in[3:0];
    assign w_cap_mu = (minutes_upper_in[3:0] > 4'd9) ? 4'd9 : minutes_upper_in[3:0];
    assign w_cap_ml = (minutes_lower_in[3:0] > 4'd9) ? 4'd9 : minutes_lower_in[3:0];

    // Next count value with the BCD carry chain; 99:59 rolls to 00:00.
    always_comb begin
        w_inc_sl = r_sl + 4'd1;
        w_inc_su = r_su;
        w_inc_ml = r_ml;
        w_inc_mu = r_mu;
        if (r_sl == 4'd9) begin
            w_inc_sl = 4'd0;
            w_inc_su = r_su + 4'd1;
            if (r_su == 4'd5) begin
                w_inc_su = 4'd0;
                w_inc_ml = r_ml + 4'd1;
                if (r_ml == 4'd9) begin
                    w_inc_ml = 4'd0;
                    w_inc_mu = (r_mu == 4'd9) ? 4'd0 : r_mu + 4'd1;
                end
            end
        end
    end

    assign w_lim_zero = ({r_lim_mu, r_lim_ml, r_lim_su, r_lim_sl} == 16'h0000);
    // Compare against the incremented value so DONE lands on the same edge
    // that loads the final count.
    assign w_hit = !w_lim_zero &&
                   ({w_inc_mu, w_inc_ml, w_inc_su, w_inc_sl} ==
                    {r_lim_mu, r_lim_ml, r_lim_su, r_lim_sl});

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_su      <= 4'd0;
            r_sl      <= 4'd0;
            r_mu      <= 4'd0;
            r_ml      <= 4'd0;
            r_lim_su  <= 4'd0;
            r_lim_sl  <= 4'd0;
            r_lim_mu  <= 4'd0;
            r_lim_ml  <= 4'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (clear) begin
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_su      <= 4'd0;
                r_sl      <= 4'd0;
                r_mu      <= 4'd0;
                r_ml      <= 4'd0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // stop outranks start even though it is a no-op here
                        if (start && !stop) begin
                            r_lim_su  <= w_cap_su;
                            r_lim_sl  <= w_cap_sl;
                            r_lim_mu  <= w_cap_mu;
                            r_lim_ml  <= w_cap_ml;
                            r_presc   <= '0;
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            // Prescaler phase is kept for the resume.
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else if (r_presc == PRESC_MAX) begin
                            r_presc <= '0;
                            r_su    <= w_inc_su;
                            r_sl    <= w_inc_sl;
                            r_mu    <= w_inc_mu;
                            r_ml    <= w_inc_ml;
                            r_tick  <= 1'b1;
                            if (w_hit) begin
                                r_state   <= S_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (start && !stop) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE: held until clear or reset
                    end
                endcase
            end
        end
    end

    assign seconds_upper = {4'h0, r_su};
    assign seconds_lower = {4'h0, r_sl};
    assign minutes_upper = {4'h0, r_mu};
    assign minutes_lower = {4'h0, r_ml};
    assign running       = r_running;
    assign done          = r_done;
    assign tick          = r_tick;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_clock_add.sv
module tb_clock_add;
  localparam int TPS = 4;

  // clock/reset block
  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [7:0] su_in = 8'h0, sl_in = 8'h0, mu_in = 8'h0, ml_in = 8'h0;
  logic [7:0] seconds_upper, seconds_lower, minutes_upper, minutes_lower;
  logic running, done, tick;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  clock_add #(.TICKS_PER_SEC(TPS)) dut (
    .CLK(CLK), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .seconds_upper_in(su_in), .seconds_lower_in(sl_in),
    .minutes_upper_in(mu_in), .minutes_lower_in(ml_in),
    .seconds_upper(seconds_upper), .seconds_lower(seconds_lower),
    .minutes_upper(minutes_upper), .minutes_lower(minutes_lower),
    .running(running), .done(done), .tick(tick), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;
  int n_ticks = 0;
  logic [34:0] exp_q[$];

  // reference model: whole seconds since 00:00, plus a sub-second phase
  int m_mode = 0; // 0 idle, 1 counting, 2 paused, 3 finished
  int m_phase = 0;
  int m_secs = 0;
  int m_limit = 0;
  bit m_tick = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int limit_secs();
    int su, sl, mu, ml;
    su = int'(su_in[3:0]); if (su > 5) su = 5;
    sl = int'(sl_in[3:0]); if (sl > 9) sl = 9;
    mu = int'(mu_in[3:0]); if (mu > 9) mu = 9;
    ml = int'(ml_in[3:0]); if (ml > 9) ml = 9;
    return (mu * 10 + ml) * 60 + su * 10 + sl;
  endfunction

  function automatic logic [34:0] snap();
    int m, s;
    m = m_secs / 60;
    s = m_secs % 60;
    return {m_tick, (m_mode == 3), (m_mode == 1),
            8'(m / 10), 8'(m % 10), 8'(s / 10), 8'(s % 10)};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_phase = 0; m_secs = 0; m_tick = 0;
  endfunction

  function automatic void model_edge(input bit st, input bit sp, input bit cl, input bit rs);
    if (!rs) begin
      model_reset();
      return;
    end
    m_tick = 0;
    if (cl) begin
      m_mode = 0; m_phase = 0; m_secs = 0;
    end else begin
      case (m_mode)
        0: if (st && !sp) begin m_limit = limit_secs(); m_phase = 0; m_mode = 1; end
        1: begin
          if (sp) m_mode = 2;
          else if (m_phase == TPS - 1) begin
            m_phase = 0;
            m_secs = (m_secs + 1) % 6000;
            m_tick = 1;
            if (m_limit != 0 && m_secs == m_limit) m_mode = 3;
          end else m_phase++;
        end
        2: if (st && !sp) m_mode = 1;
        default: ;
      endcase
    end
  endfunction

  // driver tasks
  task automatic step(input bit st, input bit sp, input bit cl, input bit rs = 1'b1);
    @(negedge CLK);
    start = st; stop = sp; clear = cl; reset = rs;
    @(posedge CLK);
    model_edge(st, sp, cl, rs);
    exp_q.push_back(snap());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic run_until_done(input int bound);
    int n;
    n = 0;
    while (m_mode != 3 && n < bound) begin
      step(0, 0, 0);
      n++;
    end
  endtask

  task automatic set_limit(input logic [7:0] su, input logic [7:0] sl,
                           input logic [7:0] mu, input logic [7:0] ml);
    su_in = su; sl_in = sl; mu_in = mu; ml_in = ml;
  endtask

  task automatic async_reset_pulse();
    @(negedge CLK);
    #2 reset = 1'b0;
    model_reset();
    #1 check("async_reset_outputs",
             {tick, done, running, minutes_upper, minutes_lower, seconds_upper, seconds_lower}, 35'd0);
    check("async_reset_state", dbg_state, 2'd0);
  endtask

  // scoreboard monitor: every sampled cycle is compared against the model
  always @(negedge CLK) begin
    if (tick === 1'b1) n_ticks++;
    if (exp_q.size() > 0) begin
      logic [34:0] e;
      e = exp_q.pop_front();
      check("cycle_outputs",
            {tick, done, running, minutes_upper, minutes_lower, seconds_upper, seconds_lower}, e);
    end
  end

  initial begin
    int t0;
    // reset state
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0);
    idle(3);

    // basic run to 00:03
    set_limit(8'h00, 8'h03, 8'h00, 8'h00);
    t0 = n_ticks;
    step(1, 0, 0);
    run_until_done(100);
    idle(6);
    step(1, 1, 0);
    idle(2);
    check("basic_tick_count", n_ticks - t0, 3);
    step(0, 0, 1);

    // carries through to 10:00
    set_limit(8'h00, 8'h00, 8'h01, 8'h00);
    t0 = n_ticks;
    step(1, 0, 0);
    run_until_done(3000);
    idle(3);
    check("carry_tick_count", n_ticks - t0, 600);
    step(0, 0, 1);

    // asynchronous reset mid-count at 00:07
    set_limit(8'h00, 8'h00, 8'h00, 8'h00);
    step(1, 0, 0);
    for (int i = 0; i < 200 && m_secs != 7; i++) step(0, 0, 0);
    async_reset_pulse();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0);
    t0 = n_ticks;
    idle(20);
    check("no_count_after_reset", n_ticks - t0, 0);

    // free run across 99:59 -> 00:00
    t0 = n_ticks;
    step(1, 0, 0);
    idle(6000 * TPS + 2);
    check("freerun_tick_count", n_ticks - t0, 6000);
    step(0, 0, 1);

    // pause with prescaler at 2 and count at 00:01, then resume
    step(1, 0, 0);
    for (int i = 0; i < 50 && !(m_secs == 1 && m_phase == 2); i++) step(0, 0, 0);
    step(0, 1, 0);
    t0 = n_ticks;
    for (int i = 0; i < 20; i++) step(0, (i % 2) == 0, 0);
    check("pause_no_tick", n_ticks - t0, 0);
    step(1, 0, 0);
    idle(4);
    step(0, 0, 1);

    // start+stop together in RUN pauses; clamped limit 00:59
    step(1, 0, 0);
    idle(5);
    step(1, 1, 0);
    idle(3);
    step(0, 0, 1);
    set_limit(8'h9F, 8'h0C, 8'h00, 8'h00);
    step(1, 0, 0);
    run_until_done(400);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    idle(2);

    // randomized control sequences against the model
    for (int r = 0; r < 4; r++) begin
      set_limit(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00,
                8'($urandom_range(0, 1)));
      step(1, 0, 0);
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      step(0, 0, 1);
    end

    @(negedge CLK);
    @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
